// File: rtl/dmem_wrapper.sv
// Single-port 128-bit line memory behind a request/response handshake.
// One request in flight; accesses complete a fixed LATENCY cycles after acceptance.
module dmem_wrapper #(
  parameter int unsigned LATENCY   = 4,
  parameter int unsigned MEM_LINES = 1024
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [31:0]  addr_i,
  input  logic         we_i,
  input  logic [127:0] data_wr_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [31:0]  rsp_mem_addr_o,
  output logic [127:0] data_line_o
);

  localparam int unsigned IDX_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state_reg, state_next;
  logic [7:0]     cnt_reg, cnt_next;
  logic [31:0]    addr_reg;
  logic           we_reg;
  logic [127:0]   wdata_reg;
  logic [31:0]    rsp_addr_reg;
  logic [127:0]   data_line_reg;
  logic           accept;
  logic           complete;
  logic [IDX_W-1:0] line_idx;

  // Contents start at zero and are deliberately outside the reset domain.
  logic [127:0] mem_reg [MEM_LINES] = '{default: '0};

  assign line_idx = addr_reg[4 +: IDX_W];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (req_valid_i) begin
          accept     = 1'b1;
          cnt_next   = 8'(LATENCY - 1);
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg == 8'd0) begin
          complete   = 1'b1;
          state_next = we_reg ? IDLE : RESP;
        end else begin
          cnt_next = cnt_reg - 8'd1;
        end
      end
      RESP: begin
        // An unknown ready falls to the else path, so the response is held.
        if (rsp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg     <= IDLE;
      cnt_reg       <= 8'd0;
      addr_reg      <= 32'd0;
      we_reg        <= 1'b0;
      wdata_reg     <= 128'd0;
      rsp_addr_reg  <= 32'd0;
      data_line_reg <= 128'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (accept) begin
        addr_reg  <= {addr_i[31:4], 4'h0};
        we_reg    <= we_i;
        wdata_reg <= data_wr_i;
      end
      if (complete && !we_reg) begin
        data_line_reg <= mem_reg[line_idx];
        rsp_addr_reg  <= addr_reg;
      end
    end
  end

  // Reset forces IDLE, so an aborted write can never reach the array.
  always_ff @(posedge clk_i) begin
    if (complete && we_reg) mem_reg[line_idx] <= wdata_reg;
  end

  assign req_ready_o    = (state_reg == IDLE);
  assign rsp_valid_o    = (state_reg == RESP);
  assign rsp_mem_addr_o = rsp_addr_reg;
  assign data_line_o    = data_line_reg;

endmodule

// File: tb/tb_dmem_wrapper.sv
// Directed bench for dmem_wrapper: queue scoreboard of expected read responses
// and a line-level reference memory.
module tb_dmem_wrapper;
  localparam int LAT = 4;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         req_valid_i;
  logic         req_ready_o;
  logic [31:0]  addr_i;
  logic         we_i;
  logic [127:0] data_wr_i;
  logic         rsp_valid_o;
  logic         rsp_ready_i;
  logic [31:0]  rsp_mem_addr_o;
  logic [127:0] data_line_o;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
  } rsp_t;

  rsp_t          exp_q[$];
  logic [127:0]  model_mem [int unsigned];
  int            n_tests = 0;
  int            n_fail  = 0;

  dmem_wrapper #(.LATENCY(LAT), .MEM_LINES(1024)) dut (
    .clk_i          (clk_i),
    .rstn_i         (rstn_i),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .addr_i         (addr_i),
    .we_i           (we_i),
    .data_wr_i      (data_wr_i),
    .rsp_valid_o    (rsp_valid_o),
    .rsp_ready_i    (rsp_ready_i),
    .rsp_mem_addr_o (rsp_mem_addr_o),
    .data_line_o    (data_line_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] model_rd(input logic [31:0] a);
    int unsigned idx;
    idx = int'(a[13:4]);
    return model_mem.exists(idx) ? model_mem[idx] : 128'd0;
  endfunction

  // Posted write: expect exactly LAT cycles of busy and no response.
  task automatic do_write(input logic [31:0] a, input logic [127:0] d);
    int n;
    req_valid_i = 1'b1; addr_i = a; we_i = 1'b1; data_wr_i = d;
    step();
    req_valid_i = 1'b0;
    model_mem[int'(a[13:4])] = d;
    n = 0;
    while (!req_ready_o && n < 100) begin
      chk("wr_no_rsp", {127'd0, rsp_valid_o}, 128'd0);
      step();
      n++;
    end
    chk("wr_busy_cycles", 128'(n), 128'(LAT));
    $display("[TB] write addr=%h data=%h busy=%0d", a, d, n);
  endtask

  // Read accepted now; response compared against the scoreboard head.
  task automatic do_read(input logic [31:0] a, input int hold);
    int   n;
    rsp_t e;
    logic [127:0] held;
    req_valid_i = 1'b1; addr_i = a; we_i = 1'b0; data_wr_i = '0;
    rsp_ready_i = (hold == 0);
    exp_q.push_back('{addr: {a[31:4], 4'h0}, data: model_rd(a)});
    step();
    req_valid_i = 1'b0;
    n = 0;
    while (!rsp_valid_o && n < 100) begin
      step();
      n++;
    end
    chk("rd_latency", 128'(n), 128'(LAT));
    e = exp_q.pop_front();
    chk("rd_data", data_line_o, e.data);
    chk("rd_addr", 128'(rsp_mem_addr_o), 128'(e.addr));
    held = data_line_o;
    for (int i = 0; i < hold; i++) begin
      rsp_ready_i = (i % 3 == 2) ? 1'bx : 1'b0;
      step();
      chk("hold_valid", {127'd0, rsp_valid_o}, 128'd1);
      chk("hold_data", data_line_o, held);
      chk("hold_ready", {127'd0, req_ready_o}, 128'd0);
    end
    rsp_ready_i = 1'b1;
    step();
    chk("rsp_drop", {127'd0, rsp_valid_o}, 128'd0);
    chk("idle_ready", {127'd0, req_ready_o}, 128'd1);
    rsp_ready_i = 1'b0;
    $display("[TB] read addr=%h data=%h lat=%0d hold=%0d", a, held, n, hold);
  endtask

  initial begin
    logic [127:0] d0, d1, d2;
    int n;
    d0 = 128'hDEADBEEF_CAFEBABE_12345678_9ABCDEF0;
    d1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    d2 = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    rstn_i = 1'b0; req_valid_i = 1'b0; addr_i = '0; we_i = 1'b0;
    data_wr_i = '0; rsp_ready_i = 1'b0;
    step(); step();
    chk("rst_ready", {127'd0, req_ready_o}, 128'd1);
    chk("rst_valid", {127'd0, rsp_valid_o}, 128'd0);
    chk("rst_addr", 128'(rsp_mem_addr_o), 128'd0);
    chk("rst_data", data_line_o, 128'd0);
    rstn_i = 1'b1;

    do_write(32'h0000_2000, d0);
    do_read(32'h0000_2000, 0);
    do_read(32'h0000_200C, 0);
    do_read(32'h0000_5000, 0);
    do_read(32'h0000_2000, 10);
    // Wrapped index: 0x42000 aliases line 0x200 with 1024 lines.
    do_read(32'h0004_2000, 0);

    // Second request held during BUSY must be dropped.
    req_valid_i = 1'b1; addr_i = 32'h0000_3000; we_i = 1'b1; data_wr_i = d1;
    step();
    model_mem[int'(32'h300)] = d1;
    addr_i = 32'h0000_4000; data_wr_i = d2;
    n = 0;
    while (!req_ready_o && n < 100) begin
      step();
      n++;
    end
    req_valid_i = 1'b0;
    chk("ign_busy_cycles", 128'(n), 128'(LAT));
    $display("[TB] write addr=00003000 with overlapping request to 00004000");
    do_read(32'h0000_4000, 0);
    do_read(32'h0000_3000, 0);

    // Reset mid-write: array keeps old line.
    req_valid_i = 1'b1; addr_i = 32'h0000_2000; we_i = 1'b1; data_wr_i = d2;
    step();
    req_valid_i = 1'b0;
    step(); step();
    rstn_i = 1'b0;
    #1;
    chk("midrst_ready", {127'd0, req_ready_o}, 128'd1);
    chk("midrst_valid", {127'd0, rsp_valid_o}, 128'd0);
    chk("midrst_addr", 128'(rsp_mem_addr_o), 128'd0);
    chk("midrst_data", data_line_o, 128'd0);
    step();
    rstn_i = 1'b1;
    $display("[TB] reset during write to 00002000");
    do_read(32'h0000_2000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_wrapper.md
DMEM_WRAPPER -- requirements
Module: dmem_wrapper

Interface
REQ-001 Parameter LATENCY, default 4, cycles from request acceptance to completion (legal range 1..255).
REQ-002 Parameter MEM_LINES, default 1024, number of 128-bit lines (power of two).
REQ-003 clk_i  in  1  single clock; all state changes on the rising edge.
REQ-004 rstn_i  in  1  reset; asynchronous, active-low.
REQ-005 req_valid_i  in  1  request valid.
REQ-006 req_ready_o  out  1  block can accept a request.
REQ-007 addr_i  in  32  byte address of the request.
REQ-008 we_i  in  1  1 = write line, 0 = read line.
REQ-009 data_wr_i  in  128  write line data.
REQ-010 rsp_valid_o  out  1  read response valid.
REQ-011 rsp_ready_i  in  1  consumer accepts the response.
REQ-012 rsp_mem_addr_o  out  32  line-aligned address of the responding request.
REQ-013 data_line_o  out  128  read line data.

Function
REQ-014 Storage: MEM_LINES x 128-bit array; line index = addr_i[4+log2(MEM_LINES)-1:4]; addr_i[3:0] ignored; higher address bits ignored, so indices wrap modulo MEM_LINES.
REQ-015 Array contents: all zeros at time 0; reset does not alter them.
REQ-016 FSM states: IDLE, BUSY, RESP.
REQ-017 req_ready_o = 1 only in IDLE; combinational from the state.
REQ-018 Acceptance: at a rising edge in IDLE with req_valid_i = 1; the edge latches addr_i, we_i and data_wr_i, loads the counter with LATENCY-1, and enters BUSY.
REQ-019 Requests presented while not IDLE are ignored; nothing is queued; at most one request is outstanding.
REQ-020 BUSY: counter decrements each edge; the edge on which it is 0 is the completion edge (acceptance edge + LATENCY).
REQ-021 Write completion: the latched data is written to the latched line; the next state is IDLE; no response is generated (posted write).
REQ-022 Read completion: data_line_o is loaded from the array; rsp_mem_addr_o = {latched addr[31:4], 4'h0}; the next state is RESP.
REQ-023 Read-after-write: a read accepted after a write completes returns the written data.
REQ-024 RESP: rsp_valid_o = 1; data_line_o and rsp_mem_addr_o are held stable until a rising edge with rsp_ready_i = 1.
REQ-025 On that edge the block returns to IDLE; rsp_valid_o is 0 from the following cycle.
REQ-026 A new request is accepted no earlier than the first edge spent in IDLE after a completion; no back-to-back bypass.
REQ-027 rsp_ready_i is ignored outside RESP; rsp_valid_o = 0 outside RESP.
REQ-028 A latency of one means completion on the edge after acceptance.
REQ-029 An X/unknown rsp_ready_i is treated as 0; the response is held.

Reset
REQ-030 While rstn_i = 0: state = IDLE; counter = 0; rsp_valid_o = 0; req_ready_o = 1; rsp_mem_addr_o = 0; data_line_o = 0.
REQ-031 Reset asserted mid-operation aborts the request; a pending write is discarded and the array is unchanged; a pending read response is dropped.
REQ-032 The first request can be accepted on the first rising edge after rstn_i deasserts.

Verification
REQ-033 Reset, then a write to addr 0x00002000 with data 0xDEADBEEF_CAFEBABE_12345678_9ABCDEF0 -> req_ready_o is 0 for 4 cycles, then 1; rsp_valid_o stays 0.
REQ-034 Read of 0x00002000 with rsp_ready_i = 1 -> rsp_valid_o = 1 exactly 4 edges after acceptance; data_line_o = 0xDEADBEEF_CAFEBABE_12345678_9ABCDEF0; rsp_mem_addr_o = 0x00002000; the response drops on the next edge.
REQ-035 Read of 0x0000200C -> same line returned; rsp_mem_addr_o = 0x00002000; a read of a never-written line returns 0.
REQ-036 Read with rsp_ready_i = 0 for 10 cycles -> rsp_valid_o and the data are held stable and req_ready_o = 0; rsp_ready_i = 1 releases the response and the block returns to IDLE.
REQ-037 req_valid_i held high during BUSY with a different address -> that request is ignored; only the first request completes.
REQ-038 rstn_i pulsed low 2 cycles after a write is accepted -> outputs return to reset values; a later read of that line returns its old contents.
